// File: rtl/b_mult_seq.sv
// b_mult_seq: sequential shift-add multiplier, signed/unsigned, with abort.
// Optional accumulate mode (MADD/MADDU) is enabled by defining B_MULT_ACCUM_EN.
module b_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_sys_clock,
    input  logic             i_sys_reset_n,
    input  logic             i_b_mult_start,
    input  logic             i_b_mult_signed,
    input  logic             i_b_mult_abort,
`ifdef B_MULT_ACCUM_EN
    input  logic             i_b_mult_acc,
`endif
    input  logic [WIDTH-1:0] i_b_mult_a_in,
    input  logic [WIDTH-1:0] i_b_mult_b_in,
    output logic             o_b_mult_busy,
    output logic             o_b_mult_done,
    output logic [WIDTH-1:0] o_b_mult_hi,
    output logic [WIDTH-1:0] o_b_mult_lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, mplier, a_mag, b_mag;
    logic [2*WIDTH-1:0] prod, prod_fix, result;
    logic [CW-1:0]      count;
    logic               neg_flag, accept;
`ifdef B_MULT_ACCUM_EN
    logic               acc_flag;
`endif

    // operand magnitudes, accept qualifier and sign/accumulate-corrected result
    always_comb begin
        a_mag    = (i_b_mult_signed && i_b_mult_a_in[WIDTH-1]) ? -i_b_mult_a_in : i_b_mult_a_in;
        b_mag    = (i_b_mult_signed && i_b_mult_b_in[WIDTH-1]) ? -i_b_mult_b_in : i_b_mult_b_in;
        accept   = (state == IDLE) && i_b_mult_start && !i_b_mult_abort;
        prod_fix = neg_flag ? -prod : prod;
`ifdef B_MULT_ACCUM_EN
        result   = acc_flag ? {o_b_mult_hi, o_b_mult_lo} + prod_fix : prod_fix;
`else
        result   = prod_fix;
`endif
    end

    // state register
    always_ff @(posedge i_sys_clock or negedge i_sys_reset_n) begin
        if (!i_sys_reset_n) state <= IDLE;
        else                state <= state_nxt;
    end

    // next state; abort always returns to IDLE, even over FIN completion
    always_comb begin
        state_nxt     = IDLE;
        o_b_mult_busy = (state != IDLE);
        case (state)
            IDLE:    state_nxt = accept ? RUN : IDLE;
            RUN:     state_nxt = i_b_mult_abort ? IDLE : (count == CW'(WIDTH - 1)) ? FIN : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: latch operands on accept, one shift-add step per RUN cycle, write back in FIN
    always_ff @(posedge i_sys_clock or negedge i_sys_reset_n) begin
        if (!i_sys_reset_n) begin
            mcand         <= '0;
            mplier        <= '0;
            prod          <= '0;
            count         <= '0;
            neg_flag      <= 1'b0;
`ifdef B_MULT_ACCUM_EN
            acc_flag      <= 1'b0;
`endif
            o_b_mult_done <= 1'b0;
            o_b_mult_hi   <= '0;
            o_b_mult_lo   <= '0;
        end else begin
            o_b_mult_done <= 1'b0;
            if (accept) begin
                mcand    <= a_mag;
                mplier   <= b_mag;
                neg_flag <= i_b_mult_signed & (i_b_mult_a_in[WIDTH-1] ^ i_b_mult_b_in[WIDTH-1]);
                prod     <= '0;
                count    <= '0;
`ifdef B_MULT_ACCUM_EN
                acc_flag <= i_b_mult_acc;
`endif
            end else if (state == RUN && !i_b_mult_abort) begin
                if (mplier[0]) prod <= prod + ({{WIDTH{1'b0}}, mcand} << count);
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end else if (state == FIN && !i_b_mult_abort) begin
                {o_b_mult_hi, o_b_mult_lo} <= result;
                o_b_mult_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_b_mult_seq.sv
// tb_b_mult_seq: directed + scoreboard bench for b_mult_seq (WIDTH=32).
module tb_b_mult_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, sgn, abort;
    logic [31:0] a, b, hi, lo;
    logic        busy, done;
`ifdef B_MULT_ACCUM_EN
    logic        acc, acc_req;
`endif
    logic [63:0] exp_q[$];
    logic [63:0] hl_model;
    int          total = 0, bad = 0, bc;

    b_mult_seq #(.WIDTH(32)) dut (
        .i_sys_clock    (clk),
        .i_sys_reset_n  (rst_n),
        .i_b_mult_start (start),
        .i_b_mult_signed(sgn),
        .i_b_mult_abort (abort),
`ifdef B_MULT_ACCUM_EN
        .i_b_mult_acc   (acc),
`endif
        .i_b_mult_a_in  (a),
        .i_b_mult_b_in  (b),
        .o_b_mult_busy  (busy),
        .o_b_mult_done  (done),
        .o_b_mult_hi    (hi),
        .o_b_mult_lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive a start at the current negedge; optionally predict and enqueue the result
    task automatic go(input logic [31:0] ta, input logic [31:0] tb_, input logic ts, input bit push);
        logic signed [63:0] sa, sb;
        logic [63:0] p, e;
        a = ta; b = tb_; sgn = ts; start = 1'b1;
        sa = {{32{ta[31]}}, ta};
        sb = {{32{tb_[31]}}, tb_};
        p  = ts ? 64'(sa * sb) : {32'b0, ta} * {32'b0, tb_};
`ifdef B_MULT_ACCUM_EN
        acc = acc_req;
        e   = acc_req ? hl_model + p : p;
`else
        e   = p;
`endif
        if (push) begin
            exp_q.push_back(e);
            hl_model = e;
        end
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; sgn = 1'($urandom);
    endtask

    // wait (bounded) for done, then pop and compare; returns busy cycles seen
    task automatic wait_done(output int cnt);
        int n = 0;
        cnt = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy) cnt++;
            @(negedge clk);
            n++;
        end
        check("done_seen", {63'b0, done}, 64'd1);
        if (done === 1'b1) begin
            check("sb_pending", {63'b0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) check("result", {hi, lo}, exp_q.pop_front());
            check("busy_in_done", {63'b0, busy}, 64'd0);
        end
    endtask

    task automatic no_done(input int n);
        logic seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (done !== 1'b0) seen = 1'b1;
        end
        check("no_done", {63'b0, seen}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; abort = 1'b0; a = '0; b = '0; hl_model = '0;
`ifdef B_MULT_ACCUM_EN
        acc = 1'b0; acc_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        // basic unsigned op, latency and one-cycle done
        go(32'd3, 32'd5, 1'b0, 1'b1);
        wait_done(bc);
        check("busy_cycles", 64'(bc), 64'd33);
        check("t1_hilo", {hi, lo}, 64'h0000_0000_0000_000F);
        @(negedge clk);
        check("done_one_cycle", {63'b0, done}, 64'd0);
        // all-ones unsigned and signed
        go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done(bc);
        check("t2_u", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_done(bc);
        check("t2_s", {hi, lo}, 64'h0000_0000_0000_0001);
        // signed corner cases
        go(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
        wait_done(bc);
        check("t3_m1x1", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        go(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        wait_done(bc);
        check("t3_minxmin", {hi, lo}, 64'h4000_0000_0000_0000);
        go(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        wait_done(bc);
        check("t3_minx1", {hi, lo}, 64'hFFFF_FFFF_8000_0000);
        // start while busy is ignored; start in done cycle accepted
        go(32'd7, 32'd9, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        go(32'd2, 32'd2, 1'b0, 1'b0);
        wait_done(bc);
        check("t4_ignored", {hi, lo}, 64'h3F);
        go(32'd2, 32'd2, 1'b0, 1'b1);
        wait_done(bc);
        check("t4_done_cycle", {hi, lo}, 64'h4);
        // abort in RUN
        go(32'd7, 32'd9, 1'b0, 1'b1);
        wait_done(bc);
        go(32'd6, 32'd6, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_run_busy", {63'b0, busy}, 64'd0);
        no_done(40);
        check("abort_run_hold", {hi, lo}, 64'h3F);
        // abort in FIN beats completion
        go(32'd5, 32'd5, 1'b0, 1'b0);
        repeat (32) @(negedge clk);
        check("fin_busy", {63'b0, busy}, 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_fin_busy", {63'b0, busy}, 64'd0);
        check("abort_fin_done", {63'b0, done}, 64'd0);
        check("abort_fin_hold", {hi, lo}, 64'h3F);
        // abort and start together in IDLE: start dropped
        abort = 1'b1; start = 1'b1; a = 32'd3; b = 32'd3;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_start_idle", {63'b0, busy}, 64'd0);
        // asynchronous reset mid-operation
        go(32'd6, 32'd6, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", {63'b0, busy}, 64'd0);
        check("async_done", {63'b0, done}, 64'd0);
        check("async_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hl_model = '0;
        no_done(40);
        check("async_after", {hi, lo}, 64'd0);
`ifdef B_MULT_ACCUM_EN
        // accumulate mode
        acc_req = 1'b0;
        go(32'd4, 32'd4, 1'b0, 1'b1);
        wait_done(bc);
        acc_req = 1'b1;
        go(32'd2, 32'd3, 1'b0, 1'b1);
        wait_done(bc);
        check("acc_add", {hi, lo}, 64'h16);
        go(32'hFFFF_FFFF, 32'h16, 1'b1, 1'b1);
        wait_done(bc);
        check("acc_signed", {hi, lo}, 64'h0);
        acc_req = 1'b0;
`endif
        // random operands against the model
        for (int i = 0; i < 6; i++) begin
            go($urandom, $urandom, 1'($urandom), 1'b1);
            wait_done(bc);
        end
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
